vjtag_dr_responder: RTL and testbench

VJTAG_DR_RESPONDER -- requirements
Module: vjtag_dr_responder

---
 rtl/vjtag_pkg.sv | 29 ++
 rtl/vjtag_shift_reg.sv | 49 ++++
 rtl/vjtag_dr_responder.sv | 185 ++++++++++++++++++
 tb/tb_vjtag_dr_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vjtag_pkg.sv
// Shared definitions for the virtual-JTAG data-register responder:
// instruction register width, instruction codes, DR FSM states and
// the instruction decode helper.
package vjtag_pkg;

    localparam int unsigned IR_W = 10;

    localparam logic [IR_W-1:0] INSTR_BYPASS = 10'h000;
    localparam logic [IR_W-1:0] INSTR_IDCODE = 10'h001;
    localparam logic [IR_W-1:0] INSTR_WRITE  = 10'h002;
    localparam logic [IR_W-1:0] INSTR_READ   = 10'h003;
    localparam logic [IR_W-1:0] INSTR_STATUS = 10'h004;
    localparam logic [IR_W-1:0] INSTR_CLEAR  = 10'h3FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_EXIT,
        ST_UPDATE
    } state_t;

    // Every code without a real data register (CLEAR and unknown codes
    // included) routes the DR path through the 1-bit bypass register.
    function automatic logic is_bypass(input logic [IR_W-1:0] code);
        return !(code inside {INSTR_IDCODE, INSTR_WRITE, INSTR_READ, INSTR_STATUS});
    endfunction

endpackage

// File: rtl/vjtag_shift_reg.sv
// DR shift path: data shift register, saturating shift counter and the
// 1-bit bypass register.
// Ports:
//   tck, reset          clock, async active-high reset
//   load, load_val      capture: load sr, clear cnt and bypass bit
//   shift, bypass_sel   shift one bit from tdi into sr or the bypass bit
//   sr, cnt, bypass_bit register state
module vjtag_shift_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              tck,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              shift,
    input  logic              bypass_sel,
    input  logic              tdi,
    output logic [DATA_W-1:0] sr,
    output logic [CNT_W-1:0]  cnt,
    output logic              bypass_bit
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W + 1);

    // Capture has precedence over shift; the counter keeps counting in
    // bypass so over/under-length shifts stay visible.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            sr         <= '0;
            cnt        <= '0;
            bypass_bit <= 1'b0;
        end else if (load) begin
            sr         <= load_val;
            cnt        <= '0;
            bypass_bit <= 1'b0;
        end else if (shift) begin
            if (bypass_sel) begin
                bypass_bit <= tdi;
            end else begin
                sr <= {tdi, sr[DATA_W-1:1]};
            end
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vjtag_dr_responder.sv
// Virtual-JTAG data-register responder: decodes the hub instruction,
// tracks the DR TAP states, shifts IDCODE/READ/STATUS words out and
// commits full-length WRITE words to the fabric.
// Ports:
//   tck, reset             clock, async active-high reset
//   tdi, tdo               serial data in/out (tdo is combinational)
//   ir_in, ir_out          instruction in, status on IR capture
//   virtual_state_*        TAP state strobes from the hub
//   wr_data, wr_valid      committed write word and its 1-cycle pulse
//   rd_data, rd_strobe     fabric read word and READ-selected pulse
// Build option: VJTAG_RESP_ERRCNT_EN adds an 8-bit saturating count of
// short/long WRITE updates, reported through STATUS.
module vjtag_dr_responder
    import vjtag_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(32'h4A54_4147)
) (
    input  logic              tck,
    input  logic              reset,
    input  logic              tdi,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_e1dr,
    input  logic              virtual_state_pdr,
    input  logic              virtual_state_e2dr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_cir,
    input  logic              virtual_state_uir,
    output logic              tdo,
    output logic [IR_W-1:0]   ir_out,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_strobe
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 2);

    state_t              state, state_d;
    logic [IR_W-1:0]     instr;
    logic [DATA_W-1:0]   sr;
    logic [CNT_W-1:0]    cnt;
    logic                bypass_bit;
    logic [DATA_W-1:0]   load_val;
    logic                wr_len_err;
    logic                wr_valid_seen;
    logic                unused_cir;

    // IR capture carries no action of its own here.
    assign unused_cir = virtual_state_cir;

    // Only the highest-priority strobe acts: cdr > sdr > udr > uir > exit/pause.
    logic sdr_go, udr_go, uir_go, ext_go;
    assign sdr_go = !virtual_state_cdr && virtual_state_sdr;
    assign udr_go = !virtual_state_cdr && !virtual_state_sdr && virtual_state_udr;
    assign uir_go = !virtual_state_cdr && !virtual_state_sdr && !virtual_state_udr
                    && virtual_state_uir;
    assign ext_go = !virtual_state_cdr && !virtual_state_sdr && !virtual_state_udr
                    && !virtual_state_uir
                    && (virtual_state_e1dr || virtual_state_pdr || virtual_state_e2dr);

    logic in_dr, sdr_acc, udr_acc, ext_acc;
    assign in_dr   = state inside {ST_CAPTURE, ST_SHIFT, ST_EXIT};
    assign sdr_acc = sdr_go && in_dr;
    assign udr_acc = udr_go && in_dr;
    assign ext_acc = ext_go && (state inside {ST_CAPTURE, ST_SHIFT});

    logic commit, len_err, clear_go;
    assign commit   = udr_acc && (instr == INSTR_WRITE) && (cnt == CNT_W'(DATA_W));
    assign len_err  = udr_acc && (instr == INSTR_WRITE) && (cnt != CNT_W'(DATA_W));
    assign clear_go = uir_go && (ir_in == INSTR_CLEAR);

`ifdef VJTAG_RESP_ERRCNT_EN
    logic [7:0] errcnt;

    // Saturating count of rejected WRITE updates.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            errcnt <= 8'h00;
        end else if (clear_go) begin
            errcnt <= 8'h00;
        end else if (len_err && (errcnt != 8'hFF)) begin
            errcnt <= errcnt + 8'd1;
        end
    end
`else
    logic [7:0] errcnt;
    assign errcnt = 8'h00;
`endif

    logic [8:0] status_word;
    assign status_word = {errcnt, wr_len_err};

    // FSM state register.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next state; cdr is honoured from any state, including UPDATE.
    always_comb begin
        state_d = state;
        if (state == ST_UPDATE) begin
            state_d = ST_IDLE;
        end
        if (virtual_state_cdr) begin
            state_d = ST_CAPTURE;
        end else if (sdr_acc) begin
            state_d = ST_SHIFT;
        end else if (udr_acc) begin
            state_d = ST_UPDATE;
        end else if (ext_acc) begin
            state_d = ST_EXIT;
        end
    end

    // Capture value for the selected data register.
    always_comb begin
        load_val = '0;
        case (instr)
            INSTR_IDCODE: load_val = ID_VALUE;
            INSTR_READ:   load_val = rd_data;
            INSTR_STATUS: load_val = DATA_W'(status_word);
            default:      load_val = '0;
        endcase
    end

    vjtag_shift_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shift_reg (
        .tck        (tck),
        .reset      (reset),
        .load       (virtual_state_cdr),
        .load_val   (load_val),
        .shift      (sdr_acc),
        .bypass_sel (is_bypass(instr)),
        .tdi        (tdi),
        .sr         (sr),
        .cnt        (cnt),
        .bypass_bit (bypass_bit)
    );

    // Instruction latch, write commit, pulses and sticky status.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            instr         <= INSTR_BYPASS;
            wr_data       <= '0;
            wr_valid      <= 1'b0;
            rd_strobe     <= 1'b0;
            wr_len_err    <= 1'b0;
            wr_valid_seen <= 1'b0;
        end else begin
            wr_valid  <= commit;
            rd_strobe <= uir_go && (ir_in == INSTR_READ);
            if (uir_go) begin
                instr <= ir_in;
            end
            if (commit) begin
                wr_data <= sr;
            end
            if (clear_go) begin
                wr_len_err    <= 1'b0;
                wr_valid_seen <= 1'b0;
            end else begin
                if (len_err) begin
                    wr_len_err <= 1'b1;
                end
                if (commit) begin
                    wr_valid_seen <= 1'b1;
                end
            end
        end
    end

    assign ir_out = {{(IR_W-2){1'b0}}, wr_valid_seen, wr_len_err};
    assign tdo    = (state == ST_IDLE) ? 1'b0
                  : (is_bypass(instr) ? bypass_bit : sr[0]);

endmodule

// File: tb/tb_vjtag_dr_responder.sv
// Randomized self-checking bench for vjtag_dr_responder with a
// transaction-level model of the committed word and status flags.
module tb_vjtag_dr_responder;

    localparam int DW = 32;
    localparam logic [7:0] S_CDR = 8'h01, S_SDR = 8'h02, S_E1 = 8'h04, S_PDR = 8'h08,
                           S_E2  = 8'h10, S_UDR = 8'h20, S_CIR = 8'h40, S_UIR = 8'h80;
    localparam logic [31:0] ID_EXP = 32'h4A54_4147;

    logic          tck = 1'b0;
    logic          reset = 1'b1;
    logic          tdi = 1'b0;
    logic [9:0]    ir_in = '0;
    logic          cdr = 0, sdr = 0, e1dr = 0, pdr = 0, e2dr = 0, udr = 0, cir = 0, uir = 0;
    logic          tdo;
    logic [9:0]    ir_out;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic [DW-1:0] rd_data = '0;
    logic          rd_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of externally visible write/status state.
    logic [31:0] m_wr_data = '0;
    logic        m_err = 1'b0;
    logic        m_seen = 1'b0;
    int          m_errcnt = 0;

    vjtag_dr_responder dut (
        .tck                (tck),
        .reset              (reset),
        .tdi                (tdi),
        .ir_in              (ir_in),
        .virtual_state_cdr  (cdr),
        .virtual_state_sdr  (sdr),
        .virtual_state_e1dr (e1dr),
        .virtual_state_pdr  (pdr),
        .virtual_state_e2dr (e2dr),
        .virtual_state_udr  (udr),
        .virtual_state_cir  (cir),
        .virtual_state_uir  (uir),
        .tdo                (tdo),
        .ir_out             (ir_out),
        .wr_data            (wr_data),
        .wr_valid           (wr_valid),
        .rd_data            (rd_data),
        .rd_strobe          (rd_strobe)
    );

    always #5 tck = ~tck;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply a strobe set for one cycle; returns at the following negedge.
    task automatic step(input logic [7:0] m);
        {uir, cir, udr, e2dr, pdr, e1dr, sdr, cdr} = m;
        @(negedge tck);
        {uir, cir, udr, e2dr, pdr, e1dr, sdr, cdr} = 8'h00;
    endtask

    task automatic load_ir(input logic [9:0] code);
        ir_in = code;
        step(S_UIR);
    endtask

    // Shift n bits LSB-first, recording tdo seen before each shift edge.
    task automatic shift(input logic [63:0] din, input int n, output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tdi = din[i];
            sdr = 1'b1;
            dout[i] = tdo;
            @(negedge tck);
        end
        sdr = 1'b0;
        tdi = 1'b0;
    endtask

    // WRITE transaction of n shifted bits; updates the model and
    // reports wr_valid right after update and one cycle later.
    task automatic do_write(input logic [31:0] w, input int n,
                            output logic v0, output logic v1, output logic exp_v);
        logic [63:0] d, junk;
        d = {$urandom, w};
        load_ir(10'h002);
        step(S_CDR);
        shift(d, n, junk);
        step(S_UDR);
        v0 = wr_valid;
        step(8'h00);
        v1 = wr_valid;
        exp_v = (n == 32);
        if (n == 32) begin
            m_wr_data = w;
            m_seen    = 1'b1;
        end else begin
            m_err = 1'b1;
`ifdef VJTAG_RESP_ERRCNT_EN
            if (m_errcnt < 255) m_errcnt++;
`endif
        end
    endtask

    task automatic test_reset;
        n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
        n_checks++; if (ir_out !== 10'h000) begin n_fail++; $display("FAIL reset_ir_out: got %h expected 000", ir_out); end
        n_checks++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        n_checks++; if (rd_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_rd_strobe: got %b expected 0", rd_strobe); end
    endtask

    task automatic test_idcode;
        logic [63:0] dout;
        load_ir(10'h001);
        step(S_CDR);
        shift({$urandom, $urandom}, 32, dout);
        n_checks++;
        if (dout[31:0] !== ID_EXP) begin
            n_fail++; $display("FAIL idcode: got %h expected %h", dout[31:0], ID_EXP);
        end
    endtask

    task automatic test_write;
        logic v0, v1, ev;
        logic [31:0] w;
        for (int k = 0; k < 5; k++) begin
            w = (k == 0) ? 32'hDEAD_BEEF : $urandom;
            do_write(w, 32, v0, v1, ev);
            n_checks++; if (v0 !== ev) begin n_fail++; $display("FAIL write_valid_pulse: got %b expected %b", v0, ev); end
            n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL write_valid_single: got %b expected 0", v1); end
            n_checks++; if (wr_data !== m_wr_data) begin n_fail++; $display("FAIL write_data: got %h expected %h", wr_data, m_wr_data); end
            n_checks++; if (ir_out !== {8'h00, m_seen, m_err}) begin n_fail++; $display("FAIL write_ir_out: got %h expected %h", ir_out, {8'h00, m_seen, m_err}); end
        end
        n_checks++; if (ir_out !== 10'h002) begin n_fail++; $display("FAIL write_ir_out_const: got %h expected 002", ir_out); end
    endtask

    task automatic test_read;
        logic [63:0] dout;
        logic [31:0] w;
        load_ir(10'h003);
        n_checks++; if (rd_strobe !== 1'b1) begin n_fail++; $display("FAIL rd_strobe_pulse: got %b expected 1", rd_strobe); end
        step(8'h00);
        n_checks++; if (rd_strobe !== 1'b0) begin n_fail++; $display("FAIL rd_strobe_single: got %b expected 0", rd_strobe); end
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 32'h1234_5678 : $urandom;
            rd_data = w;
            step(S_CDR);
            rd_data = (k == 0) ? 32'h0 : $urandom;
            shift({$urandom, $urandom}, 32, dout);
            n_checks++;
            if (dout[31:0] !== w) begin
                n_fail++; $display("FAIL read_data: got %h expected %h", dout[31:0], w);
            end
        end
    endtask

    task automatic test_pause;
        logic [63:0] junk;
        logic [31:0] w;
        logic        v0;
        w = $urandom;
        load_ir(10'h002);
        step(S_CDR);
        shift({48'h0, w[15:0]}, 16, junk);
        step(S_E1);
        step(S_PDR);
        step(S_E2);
        shift({48'h0, w[31:16]}, 16, junk);
        step(S_UDR);
        v0 = wr_valid;
        m_wr_data = w;
        m_seen = 1'b1;
        n_checks++; if (v0 !== 1'b1) begin n_fail++; $display("FAIL pause_valid: got %b expected 1", v0); end
        n_checks++; if (wr_data !== w) begin n_fail++; $display("FAIL pause_data: got %h expected %h", wr_data, w); end
        step(8'h00);
    endtask

    task automatic test_bypass;
        logic [63:0] din, dout, mask;
        logic [9:0]  codes [2];
        codes[0] = 10'h155;
        codes[1] = 10'h000;
        mask = (64'h1 << 20) - 64'h1;
        for (int k = 0; k < 2; k++) begin
            load_ir(codes[k]);
            step(S_CDR);
            din = {$urandom, $urandom} & mask;
            shift(din, 20, dout);
            n_checks++;
            if (dout !== ((din << 1) & mask)) begin
                n_fail++; $display("FAIL bypass_delay code %h: got %h expected %h", codes[k], dout, (din << 1) & mask);
            end
        end
    endtask

    task automatic test_status_read(input string tag);
        logic [63:0] dout;
        logic [31:0] exp;
        load_ir(10'h004);
        step(S_CDR);
        shift({$urandom, $urandom}, 32, dout);
        exp = {23'h0, 8'(m_errcnt), m_err};
        n_checks++;
        if (dout[31:0] !== exp) begin
            n_fail++; $display("FAIL status_%s: got %h expected %h", tag, dout[31:0], exp);
        end
    endtask

    task automatic test_short_write;
        logic v0, v1, ev;
        logic [31:0] prev;
        int n;
        prev = m_wr_data;
        do_write($urandom, 31, v0, v1, ev);
        n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL short_no_valid: got %b expected 0", v0); end
        n_checks++; if (wr_data !== prev) begin n_fail++; $display("FAIL short_data_kept: got %h expected %h", wr_data, prev); end
        n_checks++; if (ir_out[0] !== 1'b1) begin n_fail++; $display("FAIL short_err_flag: got %b expected 1", ir_out[0]); end
        test_status_read("one_error");
        for (int k = 0; k < 3; k++) begin
            n = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 31) : $urandom_range(33, 40);
            do_write($urandom, n, v0, v1, ev);
            n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL badlen_%0d_valid: got %b expected 0", n, v0); end
        end
        test_status_read("few_errors");
        for (int k = 0; k < 260; k++) do_write($urandom, 1, v0, v1, ev);
        test_status_read("saturated");
        n_checks++; if (ir_out !== {8'h00, m_seen, m_err}) begin n_fail++; $display("FAIL short_ir_out: got %h expected %h", ir_out, {8'h00, m_seen, m_err}); end
    endtask

    task automatic test_priority;
        logic [63:0] junk;
        logic [31:0] prev;
        prev = m_wr_data;
        load_ir(10'h002);
        step(S_CDR);
        shift({$urandom, $urandom}, 32, junk);
        step(S_CDR | S_UDR);
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL prio_cdr_over_udr: got %b expected 0", wr_valid); end
        step(S_UDR);
        m_err = 1'b1;
`ifdef VJTAG_RESP_ERRCNT_EN
        if (m_errcnt < 255) m_errcnt++;
`endif
        n_checks++; if (wr_data !== prev) begin n_fail++; $display("FAIL prio_data_kept: got %h expected %h", wr_data, prev); end
        n_checks++; if (ir_out !== {8'h00, m_seen, m_err}) begin n_fail++; $display("FAIL prio_ir_out: got %h expected %h", ir_out, {8'h00, m_seen, m_err}); end
    endtask

    task automatic test_clear;
        load_ir(10'h3FF);
        m_err = 1'b0;
        m_seen = 1'b0;
        m_errcnt = 0;
        n_checks++; if (ir_out !== 10'h000) begin n_fail++; $display("FAIL clear_ir_out: got %h expected 000", ir_out); end
        test_status_read("after_clear");
    endtask

    task automatic test_reset_mid_shift;
        logic [63:0] junk;
        load_ir(10'h002);
        step(S_CDR);
        shift({$urandom, $urandom}, 10, junk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tdo: got %b expected 0", tdo); end
        n_checks++; if (ir_out !== 10'h000) begin n_fail++; $display("FAIL rst_mid_ir_out: got %h expected 000", ir_out); end
        n_checks++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_wr_data: got %h expected 0", wr_data); end
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr_valid: got %b expected 0", wr_valid); end
        n_checks++; if (rd_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_strobe: got %b expected 0", rd_strobe); end
        @(negedge tck);
        reset = 1'b0;
        m_wr_data = '0; m_err = 1'b0; m_seen = 1'b0; m_errcnt = 0;
        step(S_UDR);
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_commit: got %b expected 0", wr_valid); end
        n_checks++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data_after: got %h expected 0", wr_data); end
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge tck);
        test_reset();
        reset = 1'b0;
        @(negedge tck);
        test_reset();
        test_idcode();
        test_write();
        test_read();
        test_pause();
        test_bypass();
        test_short_write();
        test_priority();
        test_clear();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
